// File: rtl/crc_control.sv
// Sequencing controller for the byte-wide CRC datapath: a 2-entry CRC_DR write buffer,
// byte feeder FSM, deferred CRC reload scheduling and host back-pressure flags.
module crc_control (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] bus_wr,
    input  logic [1:0]  bus_size,
    input  logic        buffer_write_en,
    input  logic        reset_chain,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        byte_last,
    output logic        crc_load_init,
    output logic        buffer_full,
    output logic        read_wait,
    output logic        reset_pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        INIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];
    logic [1:0]  size_q [2];
    logic [1:0]  size_d [2];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        pending_q, pending_d;

    logic        push;
    logic        pop;
    logic [1:0]  last_idx;
    logic [31:0] head_data;
    logic [7:0]  head_byte;

    always_comb begin
        head_data = data_q[head_q];

        case (size_q[head_q])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase

        case (bcnt_q)
            2'd0:    head_byte = head_data[7:0];
            2'd1:    head_byte = head_data[15:8];
            2'd2:    head_byte = head_data[23:16];
            default: head_byte = head_data[31:24];
        endcase

        // A write while full is dropped even if the head pops on the same edge.
        push = buffer_write_en && (count_q != 2'd2);
        pop  = (state_q == CALC) && (bcnt_q == last_idx);

        data_d = data_q;
        size_d = size_q;
        if (push) begin
            data_d[tail_q] = bus_wr;
            size_d[tail_q] = bus_size;
        end

        tail_d = tail_q ^ push;
        head_d = head_q ^ pop;

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        state_d = state_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    state_d = CALC;
                    bcnt_d  = 2'd0;
                end else if (pending_q) begin
                    state_d = INIT;
                end
            end
            CALC: begin
                if (pop) begin
                    bcnt_d = 2'd0;
                    if (count_d != 2'd0) begin
                        state_d = CALC;
                    end else if (pending_q) begin
                        state_d = INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + 2'd1;
                end
            end
            INIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Requests arriving while INIT executes merge into the reload already under way.
        pending_d = pending_q;
        if (state_q == INIT) begin
            pending_d = 1'b0;
        end else if (reset_chain) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            bcnt_q    <= 2'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            bcnt_q    <= bcnt_d;
            pending_q <= pending_d;
        end
    end

    // NOTE: buffer storage is not reset; count_q gates every read, so stale contents never leak.
    always_ff @(posedge HCLK) begin
        data_q <= data_d;
        size_q <= size_d;
    end

    assign byte_valid    = (state_q == CALC);
    assign byte_out      = (state_q == CALC) ? head_byte : 8'h00;
    assign byte_last     = (state_q == CALC) && (bcnt_q == last_idx);
    assign crc_load_init = (state_q == INIT);
    assign buffer_full   = (count_q == 2'd2) || pending_q;
    assign read_wait     = (count_q != 2'd0) || (state_q != IDLE);
    assign reset_pending = pending_q;

endmodule
